// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock monitor.
// Holds the FSM state encoding used by clock_monitor (IDLE/ARM/HIGH/LOW).
package clock_monitor_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

endpackage

// File: rtl/clock_monitor_if.sv
// Signal bundle between a clock monitor and whoever drives/observes it.
//   en, clk_in            : enable and monitored clock into the monitor
//   period, high_time     : last measured rise-to-rise / rise-to-fall counts
//   meas_valid            : one-cycle pulse on each new measurement
//   per_err, hi_err       : range flags for the last measurement
//   stuck                 : no edge seen for the timeout window
//   err_count             : saturating count of erroneous measurements
// master = stimulus/observer side, slave = monitor side.
interface clock_monitor_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             clk_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             per_err;
  logic             hi_err;
  logic             stuck;
  logic [7:0]       err_count;

  modport master (
    output en, clk_in,
    input  period, high_time, meas_valid, per_err, hi_err, stuck, err_count
  );

  modport slave (
    input  en, clk_in,
    output period, high_time, meas_valid, per_err, hi_err, stuck, err_count
  );
endinterface

// File: rtl/clock_monitor_sync_edge_det.sv
// Synchronizer plus edge detector for a single asynchronous input.
//   clk  : sampling clock
//   rst  : asynchronous active-low reset (all flops clear to 0)
//   din  : asynchronous input
//   rise : one-cycle strobe on a synchronized 0->1 transition
//   fall : one-cycle strobe on a synchronized 1->0 transition
// rise and fall both derive from the same (sync, prev) pair, so they can
// never be asserted together.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev;

endmodule

// File: rtl/clock_monitor.sv
// Oversampling clock monitor.
// Measures each rise-to-rise period and rise-to-fall high time of clk_in in
// clk cycles, flags out-of-range values, counts erroneous measurements and
// detects a stuck (edge-less) clk_in.
//   clk : reference clock (only clock domain)
//   rst : asynchronous active-low reset
//   mon : slave side of clock_monitor_if (en/clk_in in, results out)
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int PER_MIN     = 8,
  parameter int PER_MAX     = 12,
  parameter int HI_MIN      = 1,
  parameter int HI_MAX      = 3,
  parameter int TIMEOUT     = 1024
) (
  input  logic           clk,
  input  logic           rst,
  clock_monitor_if.slave mon
);

  logic             rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, hi_lat;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic             valid_q, per_err_q, hi_err_q, stuck_q;
  logic [7:0]       err_count_q;
  logic             per_bad, hi_bad, timeout;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (mon.clk_in),
    .rise (rise),
    .fall (fall)
  );

  // Range checks on the values that are about to be published.
  assign per_bad = (cnt < CNT_W'(PER_MIN)) || (cnt > CNT_W'(PER_MAX));
  assign hi_bad  = (hi_lat < CNT_W'(HI_MIN)) || (hi_lat > CNT_W'(HI_MAX));
  // cnt keeps climbing (saturating) after a timeout, so >= keeps stuck
  // asserted without needing to rearm the counter.
  assign timeout = (cnt >= CNT_W'(TIMEOUT)) && !rise && !fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_lat      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      per_err_q   <= 1'b0;
      hi_err_q    <= 1'b0;
      stuck_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (rise) stuck_q <= 1'b0;

      if (!mon.en) begin
        // Disabled: drop any partial measurement, keep published results.
        state  <= IDLE;
        cnt    <= '0;
        hi_lat <= '0;
      end else begin
        if (rise)          cnt <= CNT_W'(1);
        else if (cnt != '1) cnt <= cnt + 1'b1;

        case (state)
          IDLE: state <= ARM;
          ARM: begin
            if (rise)         state   <= HIGH;
            else if (timeout) stuck_q <= 1'b1;
          end
          HIGH: begin
            // A rise here means the fall was lost; restart as from ARM.
            if (rise) state <= HIGH;
            else if (fall) begin
              hi_lat <= cnt;
              state  <= LOW;
            end else if (timeout) begin
              stuck_q <= 1'b1;
              state   <= ARM;
            end
          end
          LOW: begin
            if (rise) begin
              period_q    <= cnt;
              high_time_q <= hi_lat;
              valid_q     <= 1'b1;
              per_err_q   <= per_bad;
              hi_err_q    <= hi_bad;
              if ((per_bad || hi_bad) && err_count_q != 8'hFF)
                err_count_q <= err_count_q + 8'd1;
              state <= HIGH;
            end else if (timeout) begin
              stuck_q <= 1'b1;
              state   <= ARM;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mon.period     = period_q;
  assign mon.high_time  = high_time_q;
  assign mon.meas_valid = valid_q;
  assign mon.per_err    = per_err_q;
  assign mon.hi_err     = hi_err_q;
  assign mon.stuck      = stuck_q;
  assign mon.err_count  = err_count_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: a behavioural clk_in generator, a scoreboard of
// expected measurements consumed on each meas_valid, and scenario tasks.
module tb_clock_monitor;

  logic clk;
  logic rst;

  clock_monitor_if #(.CNT_W(16)) mon_if ();

  clock_monitor #(
    .CNT_W(16), .SYNC_STAGES(2), .PER_MIN(8), .PER_MAX(12),
    .HI_MIN(1), .HI_MAX(3), .TIMEOUT(1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  typedef struct {
    int   plo;
    int   phi;
    int   hi;
    logic pe;
    logic he;
    int   gap;
  } sb_item_t;

  sb_item_t sbq[$];
  bit       sb_on;
  int       n_checks, n_fail;
  int       valid_cnt, cyc, last_vcyc;
  int       exp_err;

  // clk_in generator; all edges land at 3 mod 10 so they never coincide
  // with a clk edge (multiples of 50).
  bit gen_en, gen_jit;
  int gen_per, gen_hi;

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    int j;
    mon_if.clk_in = 1'b0;
    #3;
    forever begin
      if (gen_en) begin
        j = gen_jit ? int'($urandom_range(0, 18)) * 10 - 90 : 0;
        mon_if.clk_in = 1'b1;
        #(gen_hi);
        mon_if.clk_in = 1'b0;
        #(gen_per - gen_hi + j);
      end else begin
        #10;
      end
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    sb_item_t e;
    cyc = cyc + 1;
    if (!rst) exp_err = 0;
    else if (mon_if.meas_valid) begin
      valid_cnt = valid_cnt + 1;
      if (sb_on) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_valid: period=%0d high_time=%0d, required no valid",
                   mon_if.period, mon_if.high_time);
        end else begin
          e = sbq.pop_front();
          n_checks++;
          if (int'(mon_if.period) < e.plo || int'(mon_if.period) > e.phi) begin
            n_fail++;
            $display("FAIL period: got %0d, required %0d..%0d", mon_if.period, e.plo, e.phi);
          end
          n_checks++;
          if (int'(mon_if.high_time) !== e.hi) begin
            n_fail++;
            $display("FAIL high_time: got %0d, required %0d", mon_if.high_time, e.hi);
          end
          n_checks++;
          if (mon_if.per_err !== e.pe || mon_if.hi_err !== e.he) begin
            n_fail++;
            $display("FAIL err_flags: got per=%b hi=%b, required per=%b hi=%b",
                     mon_if.per_err, mon_if.hi_err, e.pe, e.he);
          end
          if ((e.pe || e.he) && exp_err != 255) exp_err = exp_err + 1;
          n_checks++;
          if (int'(mon_if.err_count) !== exp_err) begin
            n_fail++;
            $display("FAIL err_count: got %0d, required %0d", mon_if.err_count, exp_err);
          end
          n_checks++;
          if (mon_if.stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_on_valid: got %b, required 0", mon_if.stuck);
          end
          if (e.gap != 0) begin
            n_checks++;
            if (cyc - last_vcyc != e.gap) begin
              n_fail++;
              $display("FAIL valid_spacing: got %0d, required %0d", cyc - last_vcyc, e.gap);
            end
          end
        end
      end
      last_vcyc = cyc;
    end
  end

  task automatic wait_drain(input int budget, input string tag);
    for (int c = 0; c < budget && sbq.size() != 0; c++) @(negedge clk);
    n_checks++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d measurements outstanding, required 0", tag, sbq.size());
      sbq.delete();
    end
    sb_on = 1'b0;
  endtask

  // Disable, retune the generator, then re-enable expecting n measurements.
  task automatic run_phase(input int per, input int hi, input int n, input int plo,
                           input int phi, input int h, input logic pe, input logic he,
                           input int gap, input bit jit, input string tag);
    sb_item_t e;
    mon_if.en = 1'b0;
    sb_on = 1'b0;
    gen_per = per; gen_hi = hi; gen_jit = jit; gen_en = 1'b1;
    repeat (40) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e = '{plo, phi, h, pe, he, (i == 0) ? 0 : gap};
      sbq.push_back(e);
    end
    sb_on = 1'b1;
    mon_if.en = 1'b1;
    wait_drain(n * 20 + 200, tag);
  endtask

  task automatic push_nominal(input int n);
    sb_item_t e;
    for (int i = 0; i < n; i++) begin
      e = '{10, 10, 1, 1'b0, 1'b0, (i == 0) ? 0 : 10};
      sbq.push_back(e);
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if (mon_if.period !== 16'd0 || mon_if.high_time !== 16'd0 || mon_if.meas_valid !== 1'b0 ||
        mon_if.per_err !== 1'b0 || mon_if.hi_err !== 1'b0 || mon_if.stuck !== 1'b0 ||
        mon_if.err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values: got per=%0d hi=%0d v=%b pe=%b he=%b st=%b ec=%0d, required all 0",
               mon_if.period, mon_if.high_time, mon_if.meas_valid, mon_if.per_err,
               mon_if.hi_err, mon_if.stuck, mon_if.err_count);
    end
  endtask

  task automatic test_nominal;
    run_phase(1000, 100, 6, 10, 10, 1, 1'b0, 1'b0, 10, 1'b0, "nominal");
  endtask

  task automatic test_errors;
    run_phase(1500, 600, 260, 15, 15, 6, 1'b1, 1'b1, 15, 1'b0, "errors");
    n_checks++;
    if (mon_if.err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_saturate: got %0d, required 255", mon_if.err_count);
    end
  endtask

  task automatic test_reset_mid;
    int v;
    run_phase(1000, 100, 2, 10, 10, 1, 1'b0, 1'b0, 10, 1'b0, "pre_reset");
    @(posedge mon_if.clk_in);
    repeat (6) @(negedge clk);
    #7 rst = 1'b0;
    #1;
    test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    v = valid_cnt;
    push_nominal(2);
    sb_on = 1'b1;
    @(posedge mon_if.clk_in);
    repeat (5) @(negedge clk);
    n_checks++;
    if (valid_cnt !== v) begin
      n_fail++;
      $display("FAIL reset_first_rise_valid: got %0d valids, required 0", valid_cnt - v);
    end
    wait_drain(200, "post_reset");
  endtask

  task automatic test_stuck;
    int v;
    @(posedge mon_if.clk_in);
    gen_en = 1'b0;
    repeat (20) @(negedge clk);
    v = valid_cnt;
    repeat (980) @(negedge clk);
    n_checks++;
    if (mon_if.stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL stuck_early: got %b, required 0", mon_if.stuck);
    end
    repeat (100) @(negedge clk);
    n_checks++;
    if (mon_if.stuck !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_set: got %b, required 1", mon_if.stuck);
    end
    n_checks++;
    if (valid_cnt !== v) begin
      n_fail++;
      $display("FAIL stuck_no_valid: got %0d valids, required 0", valid_cnt - v);
    end
    push_nominal(2);
    sb_on = 1'b1;
    gen_en = 1'b1;
    @(posedge mon_if.clk_in);
    repeat (5) @(negedge clk);
    n_checks++;
    if (mon_if.stuck !== 1'b0 || valid_cnt !== v) begin
      n_fail++;
      $display("FAIL stuck_clear: got stuck=%b valids=%0d, required stuck=0 valids=0",
               mon_if.stuck, valid_cnt - v);
    end
    wait_drain(200, "resume");
  endtask

  task automatic test_en_drop;
    int v;
    sb_item_t e;
    run_phase(1000, 300, 3, 10, 10, 3, 1'b0, 1'b0, 10, 1'b0, "pre_drop");
    @(posedge mon_if.clk_in);
    repeat (5) @(negedge clk);
    mon_if.en = 1'b0;
    v = valid_cnt;
    repeat (30) @(negedge clk);
    n_checks++;
    if (valid_cnt !== v) begin
      n_fail++;
      $display("FAIL en_drop_valid: got %0d valids, required 0", valid_cnt - v);
    end
    n_checks++;
    if (mon_if.period !== 16'd10 || mon_if.high_time !== 16'd3) begin
      n_fail++;
      $display("FAIL en_drop_hold: got period=%0d high_time=%0d, required 10/3",
               mon_if.period, mon_if.high_time);
    end
    for (int i = 0; i < 3; i++) begin
      e = '{10, 10, 3, 1'b0, 1'b0, (i == 0) ? 0 : 10};
      sbq.push_back(e);
    end
    sb_on = 1'b1;
    mon_if.en = 1'b1;
    wait_drain(200, "reenable");
  endtask

  task automatic test_jitter;
    run_phase(1000, 300, 20, 9, 11, 3, 1'b0, 1'b0, 0, 1'b1, "jitter");
    n_checks++;
    if (mon_if.stuck !== 1'b0) begin
      n_fail++;
      $display("FAIL jitter_stuck: got %b, required 0", mon_if.stuck);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; valid_cnt = 0; cyc = 0; last_vcyc = 0; exp_err = 0;
    sb_on = 1'b0; gen_en = 1'b0; gen_jit = 1'b0; gen_per = 1000; gen_hi = 100;
    mon_if.en = 1'b0;
    rst = 1'b1;
    #5 rst = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_nominal();
    test_errors();
    test_reset_mid();
    test_stuck();
    test_en_drop();
    test_jitter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
